// File: rtl/uart_tx_fifo_gen2_if.sv
// Write-side bus of the UART transmitter FIFO: push/flush/clear requests in,
// occupancy and status flags out.
interface uart_tx_fifo_gen2_if #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    logic                  wren_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  flush_i;
    logic                  ovf_clr_i;
    logic                  full_o;
    logic                  empty_o;
    logic [LvlW-1:0]       level_o;
    logic                  overflow_o;

    modport master (
        output wren_i, wr_data_i, flush_i, ovf_clr_i,
        input  full_o, empty_o, level_o, overflow_o
    );

    modport slave (
        input  wren_i, wr_data_i, flush_i, ovf_clr_i,
        output full_o, empty_o, level_o, overflow_o
    );
endinterface

// File: rtl/uart_tx_fifo_gen2.sv
// UART transmitter with a character FIFO: 5..8 data bits, optional parity,
// 1 or 2 stop bits, back-to-back frames paced by an external baud tick.
module uart_tx_fifo_gen2 #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       baud_tick_i,
    input  logic       tx_en_i,
    input  logic [1:0] char_len_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       stop2_i,
    output logic       tx_o,
    output logic       busy_o,
    uart_tx_fifo_gen2_if.slave fifo_if
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0]  MaxLen = (DATA_WIDTH > 8) ? 4'd8 : 4'(DATA_WIDTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  full_q, empty_q, ovf_q, ovf_d;
    logic                  push, pop, ovf_set, frame_done;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]            len_q, len_d, cnt_q, cnt_d, len_sel;
    logic                  par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic                  par_acc_q, par_acc_d, stop_cnt_q, stop_cnt_d, tx_q, tx_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        len_sel = 4'd5 + {2'b00, char_len_i};
        if (len_sel > MaxLen) len_sel = MaxLen;
    end

    // A frame may start from idle or directly off the last stop-bit tick.
    assign frame_done = (state_q == StStop) && (!stop2_q || stop_cnt_q);
    assign pop     = baud_tick_i && tx_en_i && !empty_q && !fifo_if.flush_i &&
                     ((state_q == StIdle) || frame_done);
    assign push    = fifo_if.wren_i && !fifo_if.flush_i && (!full_q || pop);
    assign ovf_set = fifo_if.wren_i && !fifo_if.flush_i && full_q && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_set || (ovf_q && !fifo_if.ovf_clr_i);
        if (fifo_if.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            level_d = level_q + LvlW'(push) - LvlW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LvlW'(FIFO_DEPTH));
            empty_q  <= (level_d == '0);
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= fifo_if.wr_data_i;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        par_acc_d  = par_acc_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        if (baud_tick_i) begin
            unique case (state_q)
                StIdle: ;
                StStart: begin
                    state_d   = StData;
                    tx_d      = shift_q[0];
                    par_acc_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                    cnt_d     = 4'd1;
                end
                StData: begin
                    if (cnt_q == len_q) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_acc_q ^ par_odd_q;
                        end else begin
                            state_d    = StStop;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        par_acc_d = par_acc_q ^ shift_q[0];
                        shift_d   = shift_q >> 1;
                        cnt_d     = cnt_q + 4'd1;
                    end
                end
                StParity: begin
                    state_d    = StStop;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                StStop: begin
                    if (frame_done) begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // Loading a new character overrides the idle/stop transition above.
        if (pop) begin
            state_d   = StStart;
            tx_d      = 1'b0;
            shift_d   = mem_q[rd_ptr_q];
            len_d     = len_sel;
            cnt_d     = 4'd0;
            par_en_d  = parity_en_i;
            par_odd_d = parity_odd_i;
            stop2_d   = stop2_i;
            par_acc_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            par_acc_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            par_acc_q  <= par_acc_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_o               = tx_q;
    assign busy_o             = (state_q != StIdle);
    assign fifo_if.full_o     = full_q;
    assign fifo_if.empty_o    = empty_q;
    assign fifo_if.level_o    = level_q;
    assign fifo_if.overflow_o = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo_gen2.sv
// Scoreboard bench: a queue-based model predicts FIFO state and whole frames;
// a negedge monitor checks the flags and the serial line bit by bit.
module tb_uart_tx_fifo_gen2;
    localparam int unsigned Depth = 4;
    localparam int unsigned Dw    = 8;

    logic       clk = 1'b0;
    logic       rstn, tick, tx_en, par_en, par_odd, stop2;
    logic [1:0] char_len;
    logic       tx, busy;

    always #5 clk = ~clk;

    uart_tx_fifo_gen2_if #(.FIFO_DEPTH(Depth), .DATA_WIDTH(Dw)) fif ();

    uart_tx_fifo_gen2 #(.FIFO_DEPTH(Depth), .DATA_WIDTH(Dw)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .baud_tick_i  (tick),
        .tx_en_i      (tx_en),
        .char_len_i   (char_len),
        .parity_en_i  (par_en),
        .parity_odd_i (par_odd),
        .stop2_i      (stop2),
        .tx_o         (tx),
        .busy_o       (busy),
        .fifo_if      (fif)
    );

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    int unsigned vectors = 0, miscompares = 0;
    logic [7:0]  mq[$];
    frame_t      exp_q[$];
    int          ticks_left = 0;
    bit          m_ovf = 0;
    frame_t      cur;
    int          idx = 0;
    bit          in_frame = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frame_t build_frame(input logic [7:0] d, input int len, input bit pe,
                                           input bit po, input bit s2);
        frame_t f;
        bit p = 0;
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < len; i++) begin
            f.bits[1+i] = d[i];
            p ^= d[i];
        end
        f.n = 1 + len;
        if (pe) begin
            f.bits[f.n] = p ^ po;
            f.n++;
        end
        f.n += s2 ? 2 : 1;
        return f;
    endfunction

    // Applies the rules to the inputs seen at the edge that just happened.
    task automatic model_update();
        bit pop, ready, ovs;
        int pre, len;
        if (!rstn) begin
            mq.delete();
            exp_q.delete();
            ticks_left = 0;
            m_ovf = 0;
            return;
        end
        pre   = mq.size();
        ready = (ticks_left == 0) || (tick && ticks_left == 1);
        pop   = tick && tx_en && pre > 0 && !fif.flush_i && ready;
        ovs   = fif.wren_i && !fif.flush_i && pre == Depth && !pop;
        if (tick && ticks_left > 0) ticks_left--;
        if (pop) begin
            len = 5 + int'(char_len);
            exp_q.push_back(build_frame(mq.pop_front(), len, par_en, par_odd, stop2));
            ticks_left = 1 + len + (par_en ? 1 : 0) + (stop2 ? 2 : 1);
        end
        if (fif.flush_i) mq.delete();
        else if (fif.wren_i && (pre < Depth || pop)) mq.push_back(fif.wr_data_i);
        if (ovs) m_ovf = 1;
        else if (fif.ovf_clr_i) m_ovf = 0;
    endtask

    always @(negedge clk) begin
        chk("level", 32'(fif.level_o), mq.size());
        chk("full", 32'(fif.full_o), 32'(mq.size() == Depth));
        chk("empty", 32'(fif.empty_o), 32'(mq.size() == 0));
        chk("overflow", 32'(fif.overflow_o), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(ticks_left > 0));
        if (ticks_left == 0) begin
            in_frame = 0;
            chk("tx_idle", 32'(tx), 32'd1);
        end else begin
            if (!in_frame) begin
                if (exp_q.size() == 0) begin
                    chk("frame_expected", 32'd0, 32'd1);
                end else begin
                    cur = exp_q.pop_front();
                    idx = 0;
                    in_frame = 1;
                end
            end
            if (in_frame) begin
                chk("tx_bit", 32'(tx), 32'(cur.bits[idx]));
                if (tick) begin
                    idx++;
                    if (idx == cur.n) in_frame = 0;
                end
            end
        end
    end

    task automatic step(input bit w, input logic [7:0] d, input bit t, input bit f = 0,
                        input bit oc = 0);
        fif.wren_i    = w;
        fif.wr_data_i = d;
        tick          = t;
        fif.flush_i   = f;
        fif.ovf_clr_i = oc;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) step(0, 8'h00, (i % period) == period - 1);
    endtask

    task automatic cfg(input logic [1:0] cl, input bit pe, input bit po, input bit s2);
        char_len = cl;
        par_en   = pe;
        par_odd  = po;
        stop2    = s2;
    endtask

    initial begin
        rstn  = 1'b0;
        tx_en = 1'b0;
        cfg(2'd3, 0, 0, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        rstn = 1'b1;
        run(3, 2);

        // 8N1 0xA5
        tx_en = 1'b1;
        step(1, 8'hA5, 0);
        run(60, 4);
        chk("a5_empty", 32'(fif.empty_o), 32'd1);

        // 7E2 0x41
        cfg(2'd2, 1, 0, 1);
        step(1, 8'h41, 0);
        run(40, 3);

        // Overflow with tx disabled, then clear, then drain back-to-back
        cfg(2'd3, 0, 0, 0);
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), (i % 2) == 1);
        chk("ovf_full", 32'(fif.full_o), 32'd1);
        chk("ovf_level", 32'(fif.level_o), 32'd4);
        chk("ovf_flag", 32'(fif.overflow_o), 32'd1);
        step(0, 8'h00, 0, 0, 1);
        chk("ovf_clr", 32'(fif.overflow_o), 32'd0);
        tx_en = 1'b1;
        run(120, 3);

        // Push and pop on the same cycle while full
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0);
        tx_en = 1'b1;
        step(1, 8'h77, 1);
        chk("pp_level", 32'(fif.level_o), 32'd4);
        chk("pp_ovf", 32'(fif.overflow_o), 32'd0);
        run(160, 3);

        // Flush mid-frame with three entries still queued
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 0);
        tx_en = 1'b1;
        step(0, 8'h00, 1);
        run(8, 2);
        step(0, 8'h00, 0, 1);
        chk("flush_level", 32'(fif.level_o), 32'd0);
        run(60, 2);

        // Reset during DATA
        step(1, 8'h96, 0);
        step(0, 8'h00, 1);
        run(6, 2);
        rstn = 1'b0;
        step(0, 8'h00, 0);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(fif.level_o), 32'd0);
        rstn = 1'b1;
        run(30, 2);

        // Randomized traffic with config changing every cycle
        for (int i = 0; i < 4000; i++) begin
            rstn  = ($urandom_range(0, 499) != 0);
            tx_en = ($urandom_range(0, 9) < 8);
            cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step($urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0);
        end
        rstn  = 1'b1;
        tx_en = 1'b0;
        run(80, 2);
        chk("frames_left", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
